// File: rtl/uart_timp_pkg.sv
// Shared constants, state encodings and ASCII helpers for the UART time-command receiver.
package uart_timp_pkg;

    localparam logic [7:0] ASCII_T    = 8'h54;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_9    = 8'h39;
    localparam int         MAX_ORE    = 23;
    localparam int         MAX_MINUTE = 59;

    // Serial byte receiver states.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Message parser states; the four digit states are consecutive so that
    // "next digit" is simply the following encoding.
    typedef enum logic [2:0] {
        P_WAIT_T = 3'd0,
        P_H1     = 3'd1,
        P_H0     = 3'd2,
        P_M1     = 3'd3,
        P_M0     = 3'd4,
        P_END    = 3'd5
    } parse_state_t;

    // Two decimal digits combined at 7-bit width (max 99 fits).
    function automatic logic [6:0] two_digit(input logic [3:0] tens, input logic [3:0] ones);
        return 7'(tens) * 7'd10 + 7'(ones);
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop rx synchronizer plus mid-bit sampling FSM.
module uart_rx_byte
    import uart_timp_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta;
    logic             rx_sync;
    rx_state_t        state,     state_n;
    logic [CNT_W-1:0] cnt,       cnt_n;
    logic [2:0]       bit_idx,   bit_idx_n;
    logic [7:0]       shreg,     shreg_n;
    logic             stop_wait, stop_wait_n;

    // Two back-to-back flops; reset to the idle-high line level so no false start.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // State register and bit-timing datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            stop_wait <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            stop_wait <= stop_wait_n;
        end
    end

    // Next-state, sampling and one-cycle result strobes.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        stop_wait_n = stop_wait;
        byte_valid  = 1'b0;
        frame_err   = 1'b0;
        case (state)
            RX_IDLE: begin
                if (!rx_sync) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = RX_START;
                end
            end
            RX_START: begin
                if (cnt == HALF_CNT) begin
                    cnt_n   = '0;
                    state_n = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt == FULL_CNT) begin
                    cnt_n     = '0;
                    shreg_n   = {rx_sync, shreg[7:1]};
                    bit_idx_n = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (stop_wait) begin
                    // Broken frame: hold off until the line returns high.
                    if (rx_sync) begin
                        stop_wait_n = 1'b0;
                        state_n     = RX_IDLE;
                    end
                end else if (cnt == FULL_CNT) begin
                    cnt_n = '0;
                    if (rx_sync) begin
                        byte_valid = 1'b1;
                        state_n    = RX_IDLE;
                    end else begin
                        frame_err   = 1'b1;
                        stop_wait_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    assign data = shreg;

endmodule

// File: rtl/uart_timp_rx.sv
// UART time-command receiver: parses 'T' H H M M CR and loads a range-checked time.
module uart_timp_rx
    import uart_timp_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [4:0] timp_ore,
    output logic [5:0] timp_minute,
    output logic       load,
    output logic       frame_err,
    output logic       format_err
);

    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_frame_err;
    parse_state_t pstate, pstate_n;
    logic [3:0]   d_h1, d_h0, d_m1, d_m0;
    logic [6:0]   hours, minutes;
    logic         in_range;
    logic         load_n, fmt_n;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clock     (clock),
        .reset     (reset),
        .rx        (rx),
        .data      (rx_data),
        .byte_valid(rx_valid),
        .frame_err (rx_frame_err)
    );

    assign hours    = two_digit(d_h1, d_h0);
    assign minutes  = two_digit(d_m1, d_m0);
    assign in_range = (hours <= 7'(MAX_ORE)) && (minutes <= 7'(MAX_MINUTE));

    // Parser state, captured digits, committed time and registered strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            pstate      <= P_WAIT_T;
            d_h1        <= '0;
            d_h0        <= '0;
            d_m1        <= '0;
            d_m0        <= '0;
            timp_ore    <= '0;
            timp_minute <= '0;
            load        <= 1'b0;
            format_err  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            pstate     <= pstate_n;
            load       <= load_n;
            format_err <= fmt_n;
            frame_err  <= rx_frame_err;
            if (load_n) begin
                timp_ore    <= hours[4:0];
                timp_minute <= minutes[5:0];
            end
            // For '0'..'9' the low nibble is exactly the digit value.
            if (rx_valid && is_digit(rx_data)) begin
                case (pstate)
                    P_H1:    d_h1 <= rx_data[3:0];
                    P_H0:    d_h0 <= rx_data[3:0];
                    P_M1:    d_m1 <= rx_data[3:0];
                    P_M0:    d_m0 <= rx_data[3:0];
                    default: ;
                endcase
            end
        end
    end

    // Message sequencing, error classification and commit decision.
    always_comb begin
        pstate_n = pstate;
        load_n   = 1'b0;
        fmt_n    = 1'b0;
        if (rx_frame_err) begin
            pstate_n = P_WAIT_T;
        end else if (rx_valid) begin
            case (pstate)
                P_WAIT_T: begin
                    if (rx_data == ASCII_T) pstate_n = P_H1;
                end
                P_H1, P_H0, P_M1, P_M0: begin
                    if (is_digit(rx_data)) begin
                        pstate_n = parse_state_t'(pstate + 3'd1);
                    end else if (rx_data == ASCII_T) begin
                        pstate_n = P_H1;
                    end else begin
                        fmt_n    = 1'b1;
                        pstate_n = P_WAIT_T;
                    end
                end
                P_END: begin
                    if (rx_data == ASCII_CR) begin
                        load_n   = in_range;
                        fmt_n    = !in_range;
                        pstate_n = P_WAIT_T;
                    end else if (rx_data == ASCII_T) begin
                        pstate_n = P_H1;
                    end else begin
                        fmt_n    = 1'b1;
                        pstate_n = P_WAIT_T;
                    end
                end
                default: pstate_n = P_WAIT_T;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_timp_rx.sv
// Self-checking bench for uart_timp_rx: message table plus serial corner-case sequences.
module tb_uart_timp_rx;

    localparam int CLKS = 16;

    logic       clock;
    logic       reset;
    logic       rx;
    logic [4:0] timp_ore;
    logic [5:0] timp_minute;
    logic       load;
    logic       frame_err;
    logic       format_err;

    int checks   = 0;
    int failures = 0;
    int n_load   = 0;
    int n_fmt    = 0;
    int n_frm    = 0;

    uart_timp_rx #(.CLKS_PER_BIT(CLKS)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .timp_ore   (timp_ore),
        .timp_minute(timp_minute),
        .load       (load),
        .frame_err  (frame_err),
        .format_err (format_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count cycles each strobe is high, sampled mid-cycle.
    always @(negedge clock) begin
        if (load)       n_load <= n_load + 1;
        if (format_err) n_fmt  <= n_fmt + 1;
        if (frame_err)  n_frm  <= n_frm + 1;
    end

    typedef struct {
        logic [95:0] msg;
        int          len;
        int          exp_load;
        int          exp_fmt;
        int          exp_ore;
        int          exp_min;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CLKS) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLKS) @(negedge clock);
        end
        rx = stop_bit;
        repeat (CLKS) @(negedge clock);
        rx = 1'b1;
        repeat (4 * CLKS) @(negedge clock);
    endtask

    task automatic send_msg(input logic [95:0] msg, input int len);
        logic [7:0] c;
        for (int i = 0; i < len; i++) begin
            c = msg[8*(len-1-i) +: 8];
            send_byte(c, 1'b1);
        end
    endtask

    initial begin
        int l0, f0, e0;
        int rst_ore, rst_min;

        vecs[0] = '{{"T1234", 8'h0D},       6, 1, 0, 12, 34};
        vecs[1] = '{{"T2460", 8'h0D},       6, 0, 1, 12, 34};
        vecs[2] = '{{"T2359", 8'h0D},       6, 1, 0, 23, 59};
        vecs[3] = '{{"T0000", 8'h0D},       6, 1, 0,  0,  0};
        vecs[4] = '{{"T12T0905", 8'h0D},    9, 1, 0,  9,  5};
        vecs[5] = '{{"T1X"},                3, 0, 1,  9,  5};
        vecs[6] = '{{"T123456", 8'h0D},     8, 0, 1,  9,  5};
        vecs[7] = '{{"T0060", 8'h0D},       6, 0, 1,  9,  5};
        vecs[8] = '{{"T1234T0101", 8'h0D}, 11, 1, 0,  1,  1};
        vecs[9] = '{{"xyT1159", 8'h0D},     8, 1, 0, 11, 59};

        rx    = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_ore",        int'(timp_ore),    0);
        check("reset_minute",     int'(timp_minute), 0);
        check("reset_load",       int'(load),        0);
        check("reset_format_err", int'(format_err),  0);
        check("reset_frame_err",  int'(frame_err),   0);
        reset = 1'b0;
        repeat (4 * CLKS) @(negedge clock);

        for (int k = 0; k < 10; k++) begin
            l0 = n_load; f0 = n_fmt; e0 = n_frm;
            send_msg(vecs[k].msg, vecs[k].len);
            check($sformatf("vec%0d_load", k),       n_load - l0, vecs[k].exp_load);
            check($sformatf("vec%0d_format_err", k), n_fmt - f0,  vecs[k].exp_fmt);
            check($sformatf("vec%0d_frame_err", k),  n_frm - e0,  0);
            check($sformatf("vec%0d_ore", k),        int'(timp_ore),    vecs[k].exp_ore);
            check($sformatf("vec%0d_minute", k),     int'(timp_minute), vecs[k].exp_min);
        end

        // Short low glitch on the line: start is rejected at the half-bit resample.
        l0 = n_load; f0 = n_fmt; e0 = n_frm;
        rx = 1'b0;
        repeat (5) @(negedge clock);
        rx = 1'b1;
        repeat (4 * CLKS) @(negedge clock);
        check("glitch_load",       n_load - l0, 0);
        check("glitch_format_err", n_fmt - f0,  0);
        check("glitch_frame_err",  n_frm - e0,  0);

        // 'T' with a low stop bit, then the rest of a message must not load.
        l0 = n_load; f0 = n_fmt; e0 = n_frm;
        send_byte(8'h54, 1'b0);
        check("frame_frame_err", n_frm - e0, 1);
        send_msg({"1234", 8'h0D}, 5);
        check("frame_load",       n_load - l0, 0);
        check("frame_format_err", n_fmt - f0,  0);
        check("frame_ore",        int'(timp_ore),    11);
        check("frame_minute",     int'(timp_minute), 59);

        // Reset in the middle of the third character of "T1234\r".
        l0 = n_load; f0 = n_fmt;
        rst_ore = -1; rst_min = -1;
        send_msg({"T1"}, 2);
        fork
            send_byte(8'h32, 1'b1);
            begin
                repeat (CLKS * 5 / 2) @(negedge clock);
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                rst_ore = int'(timp_ore);
                rst_min = int'(timp_minute);
            end
        join
        send_msg({"34", 8'h0D}, 3);
        check("midreset_ore",        rst_ore, 0);
        check("midreset_minute",     rst_min, 0);
        check("midreset_load",       n_load - l0, 0);
        check("midreset_format_err", n_fmt - f0,  0);
        check("midreset_hold_ore",   int'(timp_ore), 0);

        l0 = n_load;
        send_msg({"T0730", 8'h0D}, 6);
        check("after_reset_load",   n_load - l0, 1);
        check("after_reset_ore",    int'(timp_ore),    7);
        check("after_reset_minute", int'(timp_minute), 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
